// File: rtl/definitions_pkg.sv
// -----------------------------------------------------------------------------
// definitions_pkg
// Shared image-pipeline definitions: frame geometry, Sobel direction codes,
// Q8 tangent thresholds and the datapath widths of the gradient stage.
// -----------------------------------------------------------------------------
package definitions_pkg;

    // Frame geometry.
    localparam int IMAGE_WIDTH  = 512;
    localparam int IMAGE_HEIGHT = 512;

    // Gradient magnitude scaling.
    localparam int MAG_SHIFT = 2;

    // tan(22.5 deg) and tan(67.5 deg) in Q8.
    localparam int TAN22_Q8 = 106;
    localparam int TAN67_Q8 = 618;

    // Datapath widths: signed gradient, its magnitude, |Gx|+|Gy| and the
    // direction-comparison products.
    localparam int GRAD_W = 11;
    localparam int ABS_W  = 10;
    localparam int SUM_W  = 11;
    localparam int PROD_W = 20;

    typedef enum logic [1:0] {
        DIR_0   = 2'd0,
        DIR_45  = 2'd1,
        DIR_90  = 2'd2,
        DIR_135 = 2'd3
    } grad_dir_t;

    // Magnitude of a signed gradient. The gradient never reaches -1024, so
    // the negated value always fits the 10-bit result.
    function automatic logic [ABS_W-1:0] abs_grad(input logic signed [GRAD_W-1:0] g);
        logic signed [GRAD_W-1:0] neg;
        neg = -g;
        if (g[GRAD_W-1]) begin
            return neg[ABS_W-1:0];
        end else begin
            return g[ABS_W-1:0];
        end
    endfunction

endpackage

// File: rtl/sobel_kernel.sv
// -----------------------------------------------------------------------------
// sobel_kernel
// Combinational Sobel Gx/Gy of one 3x3 window.
// Ports:
//   win_data [71:0]  window; row r = bits [24r+23:24r] (r=0 top),
//                    column c of a row = bits [8c+7:8c] (c=0 left)
//   gx, gy   [10:0]  signed gradients, range +/-1020
// -----------------------------------------------------------------------------
module sobel_kernel
    import definitions_pkg::*;
(
    input  logic [71:0]              win_data,
    output logic signed [GRAD_W-1:0] gx,
    output logic signed [GRAD_W-1:0] gy
);

    logic [7:0] p00, p01, p02;
    logic [7:0] p10, p12;
    logic [7:0] p20, p21, p22;

    assign p00 = win_data[7:0];
    assign p01 = win_data[15:8];
    assign p02 = win_data[23:16];
    assign p10 = win_data[31:24];
    assign p12 = win_data[47:40];
    assign p20 = win_data[55:48];
    assign p21 = win_data[63:56];
    assign p22 = win_data[71:64];

    // Each weighted column/row sum peaks at 1020, so 10 bits hold it and
    // the difference fits 11-bit signed.
    logic [9:0] gx_pos, gx_neg, gy_pos, gy_neg;

    // Weighted sums of the outer columns and rows, then their differences.
    always_comb begin
        gx_pos = {2'b00, p02} + {1'b0, p12, 1'b0} + {2'b00, p22};
        gx_neg = {2'b00, p00} + {1'b0, p10, 1'b0} + {2'b00, p20};
        gy_pos = {2'b00, p20} + {1'b0, p21, 1'b0} + {2'b00, p22};
        gy_neg = {2'b00, p00} + {1'b0, p01, 1'b0} + {2'b00, p02};
        gx     = $signed({1'b0, gx_pos}) - $signed({1'b0, gx_neg});
        gy     = $signed({1'b0, gy_pos}) - $signed({1'b0, gy_neg});
    end

endmodule

// File: rtl/sobel_gradient.sv
// -----------------------------------------------------------------------------
// sobel_gradient
// Three-stage pipeline turning one 3x3 window per valid cycle into an 8-bit
// saturated gradient magnitude and a 2-bit quantised direction, with row and
// frame position flags. Fixed latency of three cycles, no back-pressure.
// Ports:
//   clk, rstN            clock, synchronous active-low reset
//   win_data [71:0]      3x3 window (see sobel_kernel for the layout)
//   win_valid            window present this cycle
//   grad_mag [7:0]       min(255, (|Gx|+|Gy|) >> MAG_SHIFT), 0 on border columns
//   grad_dir [1:0]       0=0, 1=45, 2=90, 3=135 degrees, 0 on border columns
//   grad_valid           outputs valid
//   grad_eol, grad_eof   last window of a row / of the frame
// -----------------------------------------------------------------------------
module sobel_gradient #(
    parameter int IMAGE_WIDTH  = definitions_pkg::IMAGE_WIDTH,
    parameter int IMAGE_HEIGHT = definitions_pkg::IMAGE_HEIGHT,
    parameter int MAG_SHIFT    = definitions_pkg::MAG_SHIFT
) (
    input  logic        clk,
    input  logic        rstN,
    input  logic [71:0] win_data,
    input  logic        win_valid,
    output logic [7:0]  grad_mag,
    output logic [1:0]  grad_dir,
    output logic        grad_valid,
    output logic        grad_eol,
    output logic        grad_eof
);

    localparam int GRAD_W = definitions_pkg::GRAD_W;
    localparam int ABS_W  = definitions_pkg::ABS_W;
    localparam int SUM_W  = definitions_pkg::SUM_W;
    localparam int PROD_W = definitions_pkg::PROD_W;
    localparam int COL_W  = $clog2(IMAGE_WIDTH);
    localparam int ROW_W  = $clog2(IMAGE_HEIGHT);

    localparam logic [COL_W-1:0]  COL_LAST   = COL_W'(IMAGE_WIDTH - 1);
    localparam logic [COL_W-1:0]  COL_BORDER = COL_W'(IMAGE_WIDTH - 2);
    localparam logic [ROW_W-1:0]  ROW_LAST   = ROW_W'(IMAGE_HEIGHT - 3);
    localparam logic [PROD_W-1:0] TAN22      = PROD_W'(definitions_pkg::TAN22_Q8);
    localparam logic [PROD_W-1:0] TAN67      = PROD_W'(definitions_pkg::TAN67_Q8);

    // ---------------- window position ----------------
    logic [COL_W-1:0] col_r;
    logic [ROW_W-1:0] row_r;
    logic             eol_s, eof_s, border_s;

    // Column/row position of the window being accepted; holds on bubbles.
    always_ff @(posedge clk) begin
        if (!rstN) begin
            col_r <= {COL_W{1'b0}};
            row_r <= {ROW_W{1'b0}};
        end else if (win_valid) begin
            if (col_r == COL_LAST) begin
                col_r <= {COL_W{1'b0}};
                if (row_r == ROW_LAST) begin
                    row_r <= {ROW_W{1'b0}};
                end else begin
                    row_r <= row_r + {{(ROW_W-1){1'b0}}, 1'b1};
                end
            end else begin
                col_r <= col_r + {{(COL_W-1){1'b0}}, 1'b1};
            end
        end
    end

    // The last two columns of a row straddle the line-buffer wrap.
    always_comb begin
        eol_s    = (col_r == COL_LAST);
        eof_s    = eol_s && (row_r == ROW_LAST);
        border_s = (col_r >= COL_BORDER);
    end

    // ---------------- S1: gradients ----------------
    logic signed [GRAD_W-1:0] gx_s, gy_s;

    sobel_kernel u_kernel (
        .win_data (win_data),
        .gx       (gx_s),
        .gy       (gy_s)
    );

    logic signed [GRAD_W-1:0] s1_gx_r, s1_gy_r;
    logic                     s1_valid_r, s1_border_r, s1_eol_r, s1_eof_r;

    // S1 register: gradients plus the position flags of the window.
    always_ff @(posedge clk) begin
        if (!rstN) begin
            s1_gx_r     <= {GRAD_W{1'b0}};
            s1_gy_r     <= {GRAD_W{1'b0}};
            s1_valid_r  <= 1'b0;
            s1_border_r <= 1'b0;
            s1_eol_r    <= 1'b0;
            s1_eof_r    <= 1'b0;
        end else begin
            s1_gx_r     <= gx_s;
            s1_gy_r     <= gy_s;
            s1_valid_r  <= win_valid;
            s1_border_r <= border_s;
            s1_eol_r    <= eol_s && win_valid;
            s1_eof_r    <= eof_s && win_valid;
        end
    end

    // ---------------- S2: magnitudes and direction compares ----------------
    logic [ABS_W-1:0]  ax_s, ay_s;
    logic [SUM_W-1:0]  sum_s;
    logic [PROD_W-1:0] ay_q8_s, ax_t22_s, ax_t67_s;
    logic              lo_s, hi_s, same_s;

    // Compare ay*256 against ax*tan in Q8 to avoid a divider.
    always_comb begin
        ax_s     = definitions_pkg::abs_grad(s1_gx_r);
        ay_s     = definitions_pkg::abs_grad(s1_gy_r);
        sum_s    = {1'b0, ax_s} + {1'b0, ay_s};
        ay_q8_s  = PROD_W'(ay_s) << 8;
        ax_t22_s = PROD_W'(ax_s) * TAN22;
        ax_t67_s = PROD_W'(ax_s) * TAN67;
        lo_s     = (ay_q8_s <= ax_t22_s);
        hi_s     = (ay_q8_s >= ax_t67_s);
        same_s   = (s1_gx_r[GRAD_W-1] == s1_gy_r[GRAD_W-1]);
    end

    logic [SUM_W-1:0] s2_sum_r;
    logic             s2_lo_r, s2_hi_r, s2_same_r;
    logic             s2_valid_r, s2_border_r, s2_eol_r, s2_eof_r;

    // S2 register. ax/ay are not kept: only their sum and compares are used.
    always_ff @(posedge clk) begin
        if (!rstN) begin
            s2_sum_r    <= {SUM_W{1'b0}};
            s2_lo_r     <= 1'b0;
            s2_hi_r     <= 1'b0;
            s2_same_r   <= 1'b0;
            s2_valid_r  <= 1'b0;
            s2_border_r <= 1'b0;
            s2_eol_r    <= 1'b0;
            s2_eof_r    <= 1'b0;
        end else begin
            s2_sum_r    <= sum_s;
            s2_lo_r     <= lo_s;
            s2_hi_r     <= hi_s;
            s2_same_r   <= same_s;
            s2_valid_r  <= s1_valid_r;
            s2_border_r <= s1_border_r;
            s2_eol_r    <= s1_eol_r;
            s2_eof_r    <= s1_eof_r;
        end
    end

    // ---------------- S3: saturation and direction code ----------------
    logic [SUM_W-1:0]           shifted_s;
    logic [7:0]                 mag_s;
    definitions_pkg::grad_dir_t dir_s;

    // Border windows are forced to zero magnitude and 0-degree direction.
    always_comb begin
        shifted_s = s2_sum_r >> MAG_SHIFT;
        mag_s     = 8'd0;
        dir_s     = definitions_pkg::DIR_0;
        if (s2_border_r) begin
            mag_s = 8'd0;
            dir_s = definitions_pkg::DIR_0;
        end else begin
            if (shifted_s > SUM_W'(255)) begin
                mag_s = 8'hFF;
            end else begin
                mag_s = shifted_s[7:0];
            end
            if (s2_lo_r) begin
                dir_s = definitions_pkg::DIR_0;
            end else if (s2_hi_r) begin
                dir_s = definitions_pkg::DIR_90;
            end else if (s2_same_r) begin
                dir_s = definitions_pkg::DIR_45;
            end else begin
                dir_s = definitions_pkg::DIR_135;
            end
        end
    end

    // S3 register drives the outputs.
    always_ff @(posedge clk) begin
        if (!rstN) begin
            grad_mag   <= 8'd0;
            grad_dir   <= 2'd0;
            grad_valid <= 1'b0;
            grad_eol   <= 1'b0;
            grad_eof   <= 1'b0;
        end else begin
            grad_mag   <= mag_s;
            grad_dir   <= dir_s;
            grad_valid <= s2_valid_r;
            grad_eol   <= s2_eol_r;
            grad_eof   <= s2_eof_r;
        end
    end

endmodule

// File: tb/tb_sobel_gradient.sv
// -----------------------------------------------------------------------------
// tb_sobel_gradient
// Scoreboard bench: the driver pushes the hand-computed expected result of
// each window; a monitor pops and compares whenever grad_valid is high.
// A reduced frame height keeps the full-frame run short.
// -----------------------------------------------------------------------------
module tb_sobel_gradient;

    localparam int W    = 512;
    localparam int H    = 6;
    localparam int ROWS = H - 2;
    localparam int NVEC = 12;

    logic        clk = 1'b0;
    logic        rstN;
    logic [71:0] win_data;
    logic        win_valid;
    logic [7:0]  grad_mag;
    logic [1:0]  grad_dir;
    logic        grad_valid;
    logic        grad_eol;
    logic        grad_eof;

    always #5 clk = ~clk;

    sobel_gradient #(
        .IMAGE_WIDTH  (W),
        .IMAGE_HEIGHT (H),
        .MAG_SHIFT    (2)
    ) dut (
        .clk        (clk),
        .rstN       (rstN),
        .win_data   (win_data),
        .win_valid  (win_valid),
        .grad_mag   (grad_mag),
        .grad_dir   (grad_dir),
        .grad_valid (grad_valid),
        .grad_eol   (grad_eol),
        .grad_eof   (grad_eof)
    );

    typedef struct packed {
        logic [7:0] mag;
        logic [1:0] dir;
        logic       eol;
        logic       eof;
    } exp_t;

    exp_t exp_q[$];
    exp_t e;

    int checks    = 0;
    int errors    = 0;
    int in_count  = 0;
    int out_count = 0;
    int eol_seen  = 0;
    int eof_seen  = 0;
    int mcol      = 0;
    int mrow      = 0;

    logic [71:0] vec_win [NVEC];
    int          vec_mag [NVEC];
    int          vec_dir [NVEC];

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic logic [71:0] win9(input logic [7:0] p00, p01, p02,
                                         input logic [7:0] p10, p11, p12,
                                         input logic [7:0] p20, p21, p22);
        return {p22, p21, p20, p12, p11, p10, p02, p01, p00};
    endfunction

    // Directed windows with hand-derived magnitude and direction.
    task automatic init_vectors();
        vec_win[0]  = win9(0, 0, 100, 0, 0, 100, 0, 0, 100);          vec_mag[0]  = 100; vec_dir[0]  = 0; // Gx=400
        vec_win[1]  = win9(0, 0, 0, 0, 0, 0, 200, 200, 200);          vec_mag[1]  = 200; vec_dir[1]  = 2; // Gy=800
        vec_win[2]  = win9(0, 0, 0, 0, 0, 0, 0, 0, 255);              vec_mag[2]  = 127; vec_dir[2]  = 1; // Gx=Gy=255
        vec_win[3]  = win9(0, 0, 0, 0, 0, 0, 255, 0, 0);              vec_mag[3]  = 127; vec_dir[3]  = 3; // Gx=-255 Gy=255
        vec_win[4]  = win9(0, 0, 255, 0, 255, 255, 255, 255, 255);    vec_mag[4]  = 255; vec_dir[4]  = 1; // 1530>>2 saturates
        vec_win[5]  = win9(128, 128, 128, 128, 128, 128, 128, 128, 128); vec_mag[5] = 0; vec_dir[5]  = 0; // flat
        vec_win[6]  = win9(255, 0, 0, 0, 0, 0, 0, 0, 0);              vec_mag[6]  = 127; vec_dir[6]  = 1; // both -255
        vec_win[7]  = win9(0, 0, 100, 0, 0, 100, 0, 82, 100);         vec_mag[7]  = 141; vec_dir[7]  = 0; // ax=400 ay=164
        vec_win[8]  = win9(0, 0, 100, 0, 0, 100, 0, 83, 100);         vec_mag[8]  = 141; vec_dir[8]  = 1; // ax=400 ay=166
        vec_win[9]  = win9(0, 0, 0, 0, 0, 82, 100, 100, 100);         vec_mag[9]  = 141; vec_dir[9]  = 2; // ax=164 ay=400
        vec_win[10] = win9(0, 0, 0, 0, 0, 83, 100, 100, 100);         vec_mag[10] = 141; vec_dir[10] = 1; // ax=166 ay=400
        vec_win[11] = win9(0, 0, 0, 200, 0, 0, 0, 0, 0);              vec_mag[11] = 100; vec_dir[11] = 0; // Gx=-400
    endtask

    // Present one window for a cycle and queue its expected result.
    task automatic send(input int k);
        logic border, eol, eof;
        exp_t x;
        border    = (mcol >= W - 2);
        eol       = (mcol == W - 1);
        eof       = eol && (mrow == ROWS - 1);
        x.mag     = border ? 8'd0 : 8'(vec_mag[k]);
        x.dir     = border ? 2'd0 : 2'(vec_dir[k]);
        x.eol     = eol;
        x.eof     = eof;
        exp_q.push_back(x);
        in_count++;
        if (eol) begin
            mcol = 0;
            mrow = (mrow == ROWS - 1) ? 0 : mrow + 1;
        end else begin
            mcol = mcol + 1;
        end
        win_data  = vec_win[k];
        win_valid = 1'b1;
        @(negedge clk);
        win_valid = 1'b0;
    endtask

    task automatic bubble();
        win_valid = 1'b0;
        win_data  = 72'd0;
        @(negedge clk);
    endtask

    // Monitor: compare every valid output with the head of the scoreboard.
    always @(negedge clk) begin
        if (grad_valid === 1'b1) begin
            out_count++;
            if (grad_eol === 1'b1) eol_seen++;
            if (grad_eof === 1'b1) eof_seen++;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output: got valid mag=%0d dir=%0d, expected no output (t=%0t)",
                         grad_mag, grad_dir, $time);
            end else begin
                e = exp_q.pop_front();
                check("grad_mag", int'(grad_mag), int'(e.mag));
                check("grad_dir", int'(grad_dir), int'(e.dir));
                check("grad_eol", int'(grad_eol), int'(e.eol));
                check("grad_eof", int'(grad_eof), int'(e.eof));
            end
        end else if (rstN === 1'b1) begin
            check("flags_idle", int'({grad_eol, grad_eof}), 0);
        end
    end

    // Watchdog.
    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        init_vectors();
        rstN      = 1'b0;
        win_valid = 1'b0;
        win_data  = 72'd0;
        repeat (3) @(negedge clk);
        check("rst_valid", int'(grad_valid), 0);
        check("rst_mag",   int'(grad_mag),   0);
        check("rst_dir",   int'(grad_dir),   0);
        check("rst_eol",   int'(grad_eol),   0);
        check("rst_eof",   int'(grad_eof),   0);
        rstN = 1'b1;
        @(negedge clk);

        // Full frame: directed vectors cycled through, random bubbles.
        for (int i = 0; i < W * ROWS; i++) begin
            if (i >= NVEC && $urandom_range(0, 3) == 0) bubble();
            send(i % NVEC);
        end
        repeat (6) bubble();
        check("frame_eol_count", eol_seen, ROWS);
        check("frame_eof_count", eof_seen, 1);
        check("frame_out_count", out_count, in_count);
        check("frame_queue_empty", exp_q.size(), 0);

        // Reset in the middle of a frame with the pipeline full.
        eol_seen = 0; eof_seen = 0; in_count = 0; out_count = 0;
        for (int i = 0; i < 1000; i++) begin
            if (i < 990 && $urandom_range(0, 3) == 0) bubble();
            send(i % NVEC);
        end
        rstN      = 1'b1;
        rstN      = 1'b0;
        win_valid = 1'b0;
        @(negedge clk);
        // Windows 998 and 999 were still in S1/S2 and must be dropped.
        check("inflight_pending", exp_q.size(), 2);
        for (int i = 0; i < 3; i++) begin
            check("rst_mid_valid", int'(grad_valid), 0);
            @(negedge clk);
        end
        exp_q.delete();
        mcol = 0; mrow = 0;
        eol_seen = 0; eof_seen = 0; in_count = 0; out_count = 0;
        rstN = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check("post_rst_idle", int'(grad_valid), 0);
            @(negedge clk);
        end

        // Fresh frame after reset: first eol after exactly W windows.
        for (int i = 0; i < W + 4; i++) begin
            if ($urandom_range(0, 4) == 0) bubble();
            send((i + 3) % NVEC);
        end
        repeat (6) bubble();
        check("fresh_eol_count", eol_seen, 1);
        check("fresh_eof_count", eof_seen, 0);
        check("fresh_out_count", out_count, in_count);
        check("fresh_queue_empty", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
